// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared game FSM state codes, drop controller state enum and board defaults
package tetris_pkg;

  // Game FSM state codes, shared with the main game FSM
  localparam logic [2:0] GEN      = 3'd0;
  localparam logic [2:0] MOVE     = 3'd1;
  localparam logic [2:0] LAND     = 3'd2;
  localparam logic [2:0] CLEAR    = 3'd3;
  localparam logic [2:0] NEWBOARD = 3'd4;
  localparam logic [2:0] GAMEOVER = 3'd5;

  // Default board geometry
  localparam int DEF_WIDTH  = 10;
  localparam int DEF_HEIGHT = 20;

  // Internal state of the piece drop controller
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    REST = 2'd2,
    DEAD = 2'd3
  } drop_state_t;

endpackage

// File: rtl/piece_drop_ctrl_if.sv
// rtl/piece_drop_ctrl_if.sv - game FSM to piece drop controller signals (PIECE_DROP_HARD_DROP_EN adds hard_drop)
interface piece_drop_ctrl_if
  import tetris_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT + 1);

  logic [2:0]    fsm_state;
  logic          move_left;
  logic          move_right;
`ifdef PIECE_DROP_HARD_DROP_EN
  logic          hard_drop;
`endif
  logic          placed;
  logic          game_over;
  logic [CW-1:0] piece_col;
  logic [RW-1:0] piece_row;
  logic          piece_valid;

  // Game FSM side
  modport master (
`ifdef PIECE_DROP_HARD_DROP_EN
    output hard_drop,
`endif
    output fsm_state,
    output move_left,
    output move_right,
    input  placed,
    input  game_over,
    input  piece_col,
    input  piece_row,
    input  piece_valid
  );

  // Piece drop controller side
  modport slave (
`ifdef PIECE_DROP_HARD_DROP_EN
    input  hard_drop,
`endif
    input  fsm_state,
    input  move_left,
    input  move_right,
    output placed,
    output game_over,
    output piece_col,
    output piece_row,
    output piece_valid
  );

endinterface

// File: rtl/gravity_timer.sv
// rtl/gravity_timer.sv - gravity step counter with wrap hold and tick output
module gravity_timer #(
  parameter int DROP_TICKS = 8
) (
  input  logic clka,
  input  logic restart_n,
  input  logic en,
  input  logic hold,
  input  logic clear,
  output logic tick
);
  localparam int TW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
  localparam logic [TW-1:0] LAST = TW'(DROP_TICKS - 1);

  logic [TW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count while enabled; at the last tick wrap to zero unless a deferral holds it there
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        if (!hold) cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/piece_drop_ctrl.sv
// rtl/piece_drop_ctrl.sv - column-height tracker and 2x2 falling piece controller (PIECE_DROP_HARD_DROP_EN adds hard drop)
module piece_drop_ctrl
  import tetris_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int DROP_TICKS = 8,
  parameter int SPAWN_COL  = 4
) (
  input logic              clka,
  input logic              restart_n,
  piece_drop_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam logic [CW-1:0] SPAWN_C = CW'(SPAWN_COL);
  localparam logic [CW-1:0] MAX_C   = CW'(WIDTH - 2);
  localparam logic [RW-1:0] SPAWN_R = RW'(HEIGHT - 2);

  drop_state_t   state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] r_q, r_d;
  logic          placed_q, placed_d;
  logic          game_over_q, game_over_d;
  logic          valid_q, valid_d;
  logic [RW-1:0] col_h_q [WIDTH];
  logic [RW-1:0] col_h_d [WIDTH];

  logic [CW-1:0] c_m1, c_p1, c_p2;
  logic [RW-1:0] h_left, h_right, h_lo, h_hi, rest_h, spawn_rest, land_h;
  logic          timer_en, timer_clear, moved, tick, land, hd;

`ifdef PIECE_DROP_HARD_DROP_EN
  assign hd = bus.hard_drop;
`else
  assign hd = 1'b0;
`endif

  assign c_m1 = c_q - CW'(1);
  assign c_p1 = c_q + CW'(1);
  assign c_p2 = c_q + CW'(2);
  assign rest_h     = (h_lo > h_hi) ? h_lo : h_hi;
  assign spawn_rest = (col_h_q[SPAWN_COL] > col_h_q[SPAWN_COL+1]) ? col_h_q[SPAWN_COL] : col_h_q[SPAWN_COL+1];
  assign land_h     = rest_h + RW'(2);

  // Column heights around the piece; indices outside the board read as empty
  always_comb begin
    h_left  = '0;
    h_right = '0;
    h_lo    = '0;
    h_hi    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) == c_m1) h_left  = col_h_q[i];
      if (CW'(i) == c_p2) h_right = col_h_q[i];
      if (CW'(i) == c_q)  h_lo    = col_h_q[i];
      if (CW'(i) == c_p1) h_hi    = col_h_q[i];
    end
  end

  gravity_timer #(.DROP_TICKS(DROP_TICKS)) u_timer (
    .clka      (clka),
    .restart_n (restart_n),
    .en        (timer_en),
    .hold      (moved),
    .clear     (timer_clear),
    .tick      (tick)
  );

  assign timer_clear = (state_q != FALL) || (bus.fsm_state == NEWBOARD);

  // Next-state logic: spawn, moves, gravity, landing, and the global NEWBOARD/GAMEOVER overrides
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    r_d         = r_q;
    placed_d    = placed_q;
    game_over_d = game_over_q;
    valid_d     = valid_q;
    col_h_d     = col_h_q;
    timer_en    = 1'b0;
    moved       = 1'b0;
    land        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.fsm_state == GEN) begin
          c_d = SPAWN_C;
          r_d = SPAWN_R;
          if (spawn_rest > SPAWN_R) begin
            state_d     = DEAD;
            game_over_d = 1'b1;
          end else begin
            state_d = FALL;
            valid_d = 1'b1;
          end
        end
      end
      FALL: begin
        if (bus.fsm_state == MOVE) begin
          timer_en = 1'b1;
          if (hd) begin
            land = 1'b1;
          end else begin
            if (bus.move_left && !bus.move_right && (c_q != '0) && (h_left <= r_q)) begin
              c_d   = c_m1;
              moved = 1'b1;
            end else if (bus.move_right && !bus.move_left && (c_q < MAX_C) && (h_right <= r_q)) begin
              c_d   = c_p1;
              moved = 1'b1;
            end
            if (tick && !moved) begin
              if (r_q > rest_h) r_d = r_q - 1'b1;
              else              land = 1'b1;
            end
          end
        end
      end
      REST: begin
        if (bus.fsm_state == LAND) begin
          placed_d = 1'b0;
          state_d  = IDLE;
        end
      end
      DEAD: begin
      end
      default: state_d = IDLE;
    endcase

    // Gravity landing has r == rest_h already, so both landing paths settle at rest_h
    if (land) begin
      r_d      = rest_h;
      placed_d = 1'b1;
      valid_d  = 1'b0;
      state_d  = REST;
      for (int i = 0; i < WIDTH; i++) begin
        if (CW'(i) == c_q || CW'(i) == c_p1) col_h_d[i] = land_h;
      end
    end

    if (bus.fsm_state == GAMEOVER) valid_d = 1'b0;

    if (bus.fsm_state == NEWBOARD) begin
      for (int i = 0; i < WIDTH; i++) col_h_d[i] = '0;
      game_over_d = 1'b0;
      placed_d    = 1'b0;
      valid_d     = 1'b0;
      state_d     = IDLE;
    end
  end

  // State and board registers
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q     <= IDLE;
      c_q         <= '0;
      r_q         <= '0;
      placed_q    <= 1'b0;
      game_over_q <= 1'b0;
      valid_q     <= 1'b0;
      for (int i = 0; i < WIDTH; i++) col_h_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      r_q         <= r_d;
      placed_q    <= placed_d;
      game_over_q <= game_over_d;
      valid_q     <= valid_d;
      for (int i = 0; i < WIDTH; i++) col_h_q[i] <= col_h_d[i];
    end
  end

  assign bus.placed      = placed_q;
  assign bus.game_over   = game_over_q;
  assign bus.piece_col   = c_q;
  assign bus.piece_row   = r_q;
  assign bus.piece_valid = valid_q;

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// tb/tb_piece_drop_ctrl.sv - scoreboard bench for piece_drop_ctrl (PIECE_DROP_HARD_DROP_EN adds hard drop case)
module tb_piece_drop_ctrl;
  import tetris_pkg::*;

  localparam int EV_SPAWN  = 1;
  localparam int EV_PLACED = 2;
  localparam int EV_GO     = 3;

  typedef struct {
    int kind;
    int col;
    int row;
  } exp_t;

  logic clka = 1'b0;
  logic restart_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  piece_drop_ctrl_if #(.WIDTH(10), .HEIGHT(20)) bus ();

  piece_drop_ctrl #(
    .WIDTH(10), .HEIGHT(20), .DROP_TICKS(8), .SPAWN_COL(4)
  ) dut (
    .clka      (clka),
    .restart_n (restart_n),
    .bus       (bus)
  );

  always #5 clka = ~clka;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int col, input int row);
    exp_t e;
    e.kind = kind;
    e.col  = col;
    e.row  = row;
    exp_q.push_back(e);
  endtask

  task automatic compare_event(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event kind=%0d col=%0d row=%0d", kind, bus.piece_col, bus.piece_row);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_col", int'(bus.piece_col), e.col);
      check("event_row", int'(bus.piece_row), e.row);
    end
  endtask

  logic prev_valid = 1'b0;
  logic prev_placed = 1'b0;
  logic prev_go = 1'b0;

  // Monitor: compare each rising status edge against the next expected event
  always @(negedge clka) begin
    if (restart_n) begin
      if (bus.piece_valid && !prev_valid) compare_event(EV_SPAWN);
      if (bus.placed && !prev_placed)     compare_event(EV_PLACED);
      if (bus.game_over && !prev_go)      compare_event(EV_GO);
    end
    prev_valid  <= bus.piece_valid;
    prev_placed <= bus.placed;
    prev_go     <= bus.game_over;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic spawn();
    push(EV_SPAWN, 4, 18);
    bus.fsm_state = GEN;
    step(1);
    bus.fsm_state = MOVE;
  endtask

  task automatic wait_land(input int budget);
    int k;
    k = 0;
    while (!bus.placed && k < budget) begin
      step(1);
      k++;
    end
    check("land_seen", int'(bus.placed), 1);
  endtask

  task automatic release_piece();
    bus.fsm_state = LAND;
    step(1);
    check("placed_drop", int'(bus.placed), 0);
    bus.fsm_state = CLEAR;
    step(1);
  endtask

  task automatic drop_piece(input int n_left, input int col, input int row);
    spawn();
    push(EV_PLACED, col, row);
    if (n_left > 0) begin
      bus.move_left = 1'b1;
      step(n_left);
      bus.move_left = 1'b0;
    end
    wait_land(400);
    release_piece();
  endtask

  initial begin
    int k;
    bus.fsm_state  = CLEAR;
    bus.move_left  = 1'b0;
    bus.move_right = 1'b0;
`ifdef PIECE_DROP_HARD_DROP_EN
    bus.hard_drop  = 1'b0;
`endif
    step(3);
    check("rst_placed", int'(bus.placed), 0);
    check("rst_game_over", int'(bus.game_over), 0);
    check("rst_valid", int'(bus.piece_valid), 0);
    check("rst_col", int'(bus.piece_col), 0);
    check("rst_row", int'(bus.piece_row), 0);
    restart_n = 1'b1;
    bus.fsm_state = NEWBOARD;
    step(2);
    bus.fsm_state = CLEAR;
    step(1);

    // First piece: gravity timing and landing on the floor
    spawn();
    check("spawn_valid", int'(bus.piece_valid), 1);
    push(EV_PLACED, 4, 0);
    step(7);
    check("row_before_tick", int'(bus.piece_row), 18);
    step(1);
    check("row_after_tick", int'(bus.piece_row), 17);
    wait_land(200);
    check("valid_after_land", int'(bus.piece_valid), 0);
    step(5);
    check("placed_hold", int'(bus.placed), 1);
    release_piece();

    // Second piece: wall clamp, right moves, both-request no-op, lands in cols 2/3
    spawn();
    bus.move_left = 1'b1;
    step(10);
    check("left_clamp_col", int'(bus.piece_col), 0);
    check("row_during_moves", int'(bus.piece_row), 17);
    bus.move_left  = 1'b0;
    bus.move_right = 1'b1;
    step(2);
    check("right_col", int'(bus.piece_col), 2);
    bus.move_left = 1'b1;
    step(3);
    check("both_col", int'(bus.piece_col), 2);
    bus.move_left  = 1'b0;
    bus.move_right = 1'b0;
    push(EV_PLACED, 2, 0);
    wait_land(400);
    release_piece();

    // Build columns 2/3 up to height 10
    for (int h = 2; h <= 8; h += 2) drop_piece(2, 2, h);

    // Left move blocked by the tall column 3; lands on col_h[4] = 2
    spawn();
    k = 0;
    while (bus.piece_row != 6 && k < 300) begin
      step(1);
      k++;
    end
    check("wait_row6", int'(bus.piece_row), 6);
    bus.move_left = 1'b1;
    push(EV_PLACED, 4, 2);
    step(3);
    check("blocked_col", int'(bus.piece_col), 4);
    wait_land(400);
    bus.move_left = 1'b0;
    release_piece();

    // Stack columns 4/5 to the top, then spawn is blocked
    for (int h = 4; h <= 18; h += 2) drop_piece(0, 4, h);
    push(EV_GO, 4, 18);
    bus.fsm_state = GEN;
    step(1);
    bus.fsm_state = CLEAR;
    check("dead_valid", int'(bus.piece_valid), 0);
    check("dead_game_over", int'(bus.game_over), 1);
    step(3);
    check("dead_hold", int'(bus.game_over), 1);
    bus.fsm_state = NEWBOARD;
    step(1);
    check("newboard_game_over", int'(bus.game_over), 0);
    bus.fsm_state = CLEAR;
    step(1);

    // Cleared board: a piece over former tall columns reaches the floor
    drop_piece(2, 2, 0);

`ifdef PIECE_DROP_HARD_DROP_EN
    spawn();
    step(2);
    bus.hard_drop = 1'b1;
    push(EV_PLACED, 4, 0);
    step(1);
    bus.hard_drop = 1'b0;
    check("hd_placed", int'(bus.placed), 1);
    check("hd_row", int'(bus.piece_row), 0);
    release_piece();
    drop_piece(0, 4, 2);
`endif

    step(2);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
